mem_a_ctrl: RTL and testbench

// Sequencer for the banked URAM operand buffer holding matrix A. Accepts an AXI-stream tile,

---
 rtl/mem_a_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_a_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_a_ctrl.sv
// Sequencer for the banked matrix-A operand buffer: scatters an AXI-stream tile round-robin
// across banks, waits for the write pipeline to drain, then replays the rows REPEAT times.
module mem_a_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned BANKS  = 16,
  parameter int unsigned WR_LAT = 2,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW:0]      cfg_rows,
  input  logic [7:0]       cfg_repeat,
  output logic             busy,
  output logic             done,
  output logic             err_len,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [BANKS-1:0] weA,
  output logic [BANKS-1:0] enA,
  output logic [AW-1:0]    addrA,
  output logic [WIDTH-1:0] dinA,
  output logic [BANKS-1:0] enB,
  output logic [AW-1:0]    addrB,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic             rd_last
);

  localparam int unsigned BW = $clog2(BANKS);
  localparam int unsigned CW = $clog2(WR_LAT + RD_LAT + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StRead, StFlush} state_e;

  state_e            state_q, state_d;
  logic [AW:0]       rows_q, rd_rows_q, wrow_q, rrow_q;
  logic [7:0]        rep_q, pass_q;
  logic [BW-1:0]     bank_q;
  logic [CW-1:0]     cnt_q;
  logic [RD_LAT-1:0] vld_sr_q, last_sr_q;
  logic [BANKS-1:0]  we_q;
  logic [AW-1:0]     addr_a_q;
  logic [WIDTH-1:0]  din_q;
  logic              err_q;

  logic hs, row_full, load_end, issue, final_issue, rrow_wrap;

  always_comb begin
    hs          = s_axis_tvalid && (state_q == StLoad);
    row_full    = (bank_q == BW'(BANKS - 1)) && (wrow_q == rows_q - (AW+1)'(1));
    load_end    = hs && (row_full || s_axis_tlast);
    issue       = (state_q == StRead) && rd_ready;
    rrow_wrap   = (rrow_q == rd_rows_q - (AW+1)'(1));
    final_issue = issue && rrow_wrap && (pass_q == rep_q - 8'd1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if (load_end) state_d = StDrain;
      StDrain: if (cnt_q == CW'(WR_LAT - 1)) state_d = StRead;
      StRead:  if (final_issue) state_d = StFlush;
      StFlush: if (cnt_q == CW'(RD_LAT - 1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rows_q    <= '0;
      rd_rows_q <= '0;
      wrow_q    <= '0;
      rrow_q    <= '0;
      rep_q     <= '0;
      pass_q    <= '0;
      bank_q    <= '0;
      vld_sr_q  <= '0;
      last_sr_q <= '0;
      we_q      <= '0;
      addr_a_q  <= '0;
      din_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // cnt_q measures time spent in the current state
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
      we_q    <= '0;

      if (state_q == StIdle && start) begin
        rows_q <= (cfg_rows == '0 || cfg_rows > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_rows;
        rep_q  <= (cfg_repeat == 8'd0) ? 8'd1 : cfg_repeat;
        err_q  <= 1'b0;
        bank_q <= '0;
        wrow_q <= '0;
        rrow_q <= '0;
        pass_q <= '0;
      end

      if (hs) begin
        we_q     <= BANKS'(1) << bank_q;
        addr_a_q <= wrow_q[AW-1:0];
        din_q    <= s_axis_tdata;
        if (bank_q == BW'(BANKS - 1)) begin
          bank_q <= '0;
          wrow_q <= wrow_q + (AW+1)'(1);
        end else begin
          bank_q <= bank_q + BW'(1);
        end
      end

      // A partial last row still counts as a readable row
      if (load_end) begin
        rd_rows_q <= wrow_q + (AW+1)'(1);
        if (row_full ^ s_axis_tlast) err_q <= 1'b1;
      end

      if (issue) begin
        if (rrow_wrap) begin
          rrow_q <= '0;
          pass_q <= pass_q + 8'd1;
        end else begin
          rrow_q <= rrow_q + (AW+1)'(1);
        end
      end

      vld_sr_q  <= RD_LAT'({vld_sr_q, issue});
      last_sr_q <= RD_LAT'({last_sr_q, final_issue});
    end
  end

  assign busy          = (state_q != StIdle);
  assign s_axis_tready = (state_q == StLoad);
  assign err_len       = err_q;
  assign weA           = we_q;
  assign enA           = we_q;
  assign addrA         = addr_a_q;
  assign dinA          = din_q;
  assign enB           = {BANKS{issue}};
  assign addrB         = rrow_q[AW-1:0];
  assign rd_valid      = vld_sr_q[RD_LAT-1];
  assign rd_last       = last_sr_q[RD_LAT-1];
  assign done          = vld_sr_q[RD_LAT-1] && last_sr_q[RD_LAT-1];

endmodule

// File: tb/tb_mem_a_ctrl.sv
// Directed bench for mem_a_ctrl: table of tile shapes with hand-computed load/read results,
// plus a reset-during-READ sequence.
module tb_mem_a_ctrl;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned BANKS  = 16;
  localparam int unsigned WR_LAT = 2;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned AW     = 9;

  logic             clk, rst, start;
  logic [AW:0]      cfg_rows;
  logic [7:0]       cfg_repeat;
  logic             busy, done, err_len;
  logic [WIDTH-1:0] s_axis_tdata;
  logic             s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [BANKS-1:0] weA, enA, enB;
  logic [AW-1:0]    addrA, addrB;
  logic [WIDTH-1:0] dinA;
  logic             rd_ready, rd_valid, rd_last;

  mem_a_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .BANKS (BANKS),
    .WR_LAT(WR_LAT),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_rows     (cfg_rows),
    .cfg_repeat   (cfg_repeat),
    .busy         (busy),
    .done         (done),
    .err_len      (err_len),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .weA          (weA),
    .enA          (enA),
    .addrA        (addrA),
    .dinA         (dinA),
    .enB          (enB),
    .addrB        (addrB),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_last      (rd_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int rows;
    int rep;
    int nbeats;
    int tlast_at;     // 1-based beat carrying tlast, 0 = never
    int mode;         // 0: rd_ready always high, 1: toggling
    int exp_beats;
    int exp_rd_rows;
    int exp_pass;
    int exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] beat_data(input int tile, input int i);
    return WIDTH'((tile << 20) | i);
  endfunction

  task automatic run_tile(input vec_t v, input int tile);
    int acc, he, rd_idx, total, prev_we;
    bit pend_v, pend_l, fin, rd_window, exp_en;
    logic [BANKS-1:0] exp_we;
    acc = 0; he = -1; rd_idx = 0; prev_we = -1;
    pend_v = 0; pend_l = 0; fin = 0;
    total = v.exp_rd_rows * v.exp_pass;
    @(negedge clk);
    start = 1'b1; cfg_rows = (AW+1)'(v.rows); cfg_repeat = 8'(v.rep);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      exp_we = (prev_we >= 0) ? (BANKS'(1) << (prev_we % BANKS)) : '0;
      check("weA", 64'(weA), 64'(exp_we));
      check("enA", 64'(enA), 64'(exp_we));
      if (prev_we >= 0) begin
        check("addrA", 64'(addrA), 64'(prev_we / BANKS));
        check("dinA", 64'(dinA), 64'(beat_data(tile, prev_we)));
      end
      check("rd_valid", 64'(rd_valid), 64'(pend_v));
      check("rd_last", 64'(rd_last), 64'(pend_l));
      check("done", 64'(done), 64'(pend_l));
      check("busy", 64'(busy), 64'd1);
      if (n == 0) check("err_len_clear", 64'(err_len), 64'd0);
      if (pend_l) begin
        fin = 1;
        break;
      end
      prev_we = -1;
      pend_v  = 0;
      s_axis_tvalid = (acc < v.nbeats);
      s_axis_tdata  = beat_data(tile, acc);
      s_axis_tlast  = (acc + 1 == v.tlast_at);
      rd_window = (he >= 0) && (n >= he + 1 + int'(WR_LAT));
      rd_ready  = (v.mode == 0) ? 1'b1 : (n % 2 == 1);
      #1;
      check("tready", 64'(s_axis_tready), 64'(acc < v.exp_beats));
      if (s_axis_tvalid && acc < v.exp_beats) begin
        prev_we = acc;
        if (acc + 1 == v.exp_beats) he = n;
        acc++;
      end
      exp_en = rd_window && rd_ready && (rd_idx < total);
      check("enB", 64'(enB), exp_en ? 64'(16'hffff) : 64'd0);
      if (exp_en) begin
        check("addrB", 64'(addrB), 64'(rd_idx % v.exp_rd_rows));
        rd_idx++;
        pend_v = 1;
        pend_l = (rd_idx == total);
      end
      @(negedge clk);
    end
    if (!fin) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: tile %0d never delivered its last read", tile);
    end
    @(negedge clk);
    check("busy_end", 64'(busy), 64'd0);
    check("rd_valid_end", 64'(rd_valid), 64'd0);
    check("enB_end", 64'(enB), 64'd0);
    check("tready_end", 64'(s_axis_tready), 64'd0);
    check("err_len", 64'(err_len), 64'(v.exp_err));
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    rd_ready      = 1'b0;
  endtask

  task automatic check_idle_outputs();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err_len", 64'(err_len), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_weA", 64'(weA), 64'd0);
    check("rst_enA", 64'(enA), 64'd0);
    check("rst_addrA", 64'(addrA), 64'd0);
    check("rst_dinA", 64'(dinA), 64'd0);
    check("rst_enB", 64'(enB), 64'd0);
    check("rst_addrB", 64'(addrB), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_last", 64'(rd_last), 64'd0);
  endtask

  initial begin
    //          rows rep nbeats tlast mode beats rdrows pass err
    vecs[0] = '{2,   1,  32,    32,   0,   32,   2,     1,   0};
    vecs[1] = '{4,   3,  64,    64,   0,   64,   4,     3,   0};
    vecs[2] = '{3,   2,  48,    48,   1,   48,   3,     2,   0};
    vecs[3] = '{4,   1,  20,    20,   0,   20,   2,     1,   1};
    vecs[4] = '{1,   1,  20,    0,    0,   16,   1,     1,   1};
    vecs[5] = '{1,   0,  16,    16,   1,   16,   1,     1,   0};
    vecs[6] = '{0,   1,  17,    17,   0,   17,   2,     1,   1};
    vecs[7] = '{3,   1,  16,    16,   0,   16,   1,     1,   1};

    rst = 1'b1; start = 1'b0; cfg_rows = '0; cfg_repeat = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs();

    for (int k = 0; k < 8; k++) run_tile(vecs[k], k + 1);

    // Reset while sitting in READ with an issue pending on the same edge
    @(negedge clk);
    start = 1'b1; cfg_rows = 10'd2; cfg_repeat = 8'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beat_data(50, i);
      s_axis_tlast  = (i == 31);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (4) @(negedge clk);
    check("read_hold_busy", 64'(busy), 64'd1);
    check("read_hold_enB", 64'(enB), 64'd0);
    rd_ready = 1'b1;
    rst      = 1'b1;
    #1;
    check("pre_rst_enB", 64'(enB), 64'(16'hffff));
    check("pre_rst_addrB", 64'(addrB), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_rd_valid", 64'(rd_valid), 64'd0);
    check("post_rst_enB", 64'(enB), 64'd0);
    check("post_rst_done", 64'(done), 64'd0);
    rd_ready = 1'b0;
    run_tile(vecs[0], 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
